// File: rtl/bcd_pkg.sv
// Shared constants, state type and digit helpers for the BCD serial datapath.
package bcd_pkg;

    localparam int BCD_W    = 4;
    localparam int BCD_MAX  = 9;
    localparam int BCD_CORR = 6;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Nine's complement of one BCD digit (9 - d).
    function automatic logic [BCD_W-1:0] nines_comp(input logic [BCD_W-1:0] d);
        return BCD_W'(BCD_MAX) - d;
    endfunction

    // A digit is legal BCD when it does not exceed 9.
    function automatic logic digit_valid(input logic [BCD_W-1:0] d);
        return (d <= BCD_W'(BCD_MAX));
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit combinational BCD adder with decimal carry.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] i_a_d,
    input  logic [BCD_W-1:0] i_b_d,
    input  logic             i_cin,
    output logic [BCD_W-1:0] o_d,
    output logic             o_cout
);

    logic [BCD_W:0] w_t;

    assign w_t = {1'b0, i_a_d} + {1'b0, i_b_d} + {{BCD_W{1'b0}}, i_cin};

    // Binary sums above 9 are pushed past 15 by +6 so the low nibble is the decimal digit.
    always_comb begin
        if (w_t > (BCD_W + 1)'(BCD_MAX)) begin
            o_d    = w_t[BCD_W-1:0] + BCD_W'(BCD_CORR);
            o_cout = 1'b1;
        end else begin
            o_d    = w_t[BCD_W-1:0];
            o_cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder/subtractor, one digit per clock, LSD first, start/done handshake.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_sub,
    input  logic [BCD_W*DIGITS-1:0] i_a,
    input  logic [BCD_W*DIGITS-1:0] i_b,
    input  logic                  i_c_in,
    output logic [BCD_W*DIGITS-1:0] o_sum,
    output logic                  o_c_out,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_invalid
);

    localparam int W     = BCD_W * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_res;
    logic             r_carry;
    logic             r_bad;
    logic [W-1:0]     r_sum;
    logic             r_c_out;
    logic             r_busy;
    logic             r_done;
    logic             r_invalid;

    logic [W-1:0]     w_b_cap;
    logic             w_bad;
    logic [W-1:0]     w_res_full;
    logic [BCD_W-1:0] w_a_d;
    logic [BCD_W-1:0] w_b_d;
    logic [BCD_W-1:0] w_d;
    logic             w_cout;
    logic             w_last;

    // Operand B as captured (nine's complemented for subtraction) and raw-digit validity.
    always_comb begin
        w_b_cap = i_b;
        w_bad   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (i_sub) begin
                w_b_cap[i*BCD_W +: BCD_W] = nines_comp(i_b[i*BCD_W +: BCD_W]);
            end
            if (!digit_valid(i_a[i*BCD_W +: BCD_W]) || !digit_valid(i_b[i*BCD_W +: BCD_W])) begin
                w_bad = 1'b1;
            end
        end
    end

    assign w_a_d  = r_a[r_cnt*BCD_W +: BCD_W];
    assign w_b_d  = r_b[r_cnt*BCD_W +: BCD_W];
    assign w_last = (r_cnt == CNT_W'(DIGITS - 1));

    // Working result with the digit being produced this cycle merged in.
    always_comb begin
        w_res_full = r_res;
        w_res_full[r_cnt*BCD_W +: BCD_W] = w_d;
    end

    bcd_digit_add u_digit_add (
        .i_a_d  (w_a_d),
        .i_b_d  (w_b_d),
        .i_cin  (r_carry),
        .o_d    (w_d),
        .o_cout (w_cout)
    );

    // Control FSM, digit counter, working registers and held outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_bad     <= 1'b0;
            r_sum     <= '0;
            r_c_out   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_invalid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= w_b_cap;
                        // Subtraction is a + nines(b) + 1 - borrow_in.
                        r_carry <= i_sub ? ~i_c_in : i_c_in;
                        r_bad   <= w_bad;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_res   <= w_res_full;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_sum     <= r_bad ? '0 : w_res_full;
                        r_c_out   <= r_bad ? 1'b0 : w_cout;
                        r_invalid <= r_bad;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_sum     = r_sum;
    assign o_c_out   = r_c_out;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_invalid = r_invalid;

endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
Parametrised multi-digit BCD adder/subtractor, processed digit-serially (one BCD digit per clock, LSD first) behind a start/done handshake. It extends the team's single-digit combinational BCD adder to N digits and adds the following:
- ten's-complement subtraction;
- input-digit validity checking;
- registered, held results.

It sits between operand registers and display/accumulator logic in the BCD arithmetic datapath.

Parameters:
DIGITS, 4, number of BCD digits per operand (legal range 1..16).

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request operation; sampled only when idle.
sub  input  1  0 = a+b+c_in; 1 = a-b-c_in (c_in acts as borrow-in).
a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
b  input  4*DIGITS  operand B, packed BCD.
c_in  input  1  carry-in (add) / borrow-in (sub).
sum  output  4*DIGITS  registered BCD result, held until next completion.
c_out  output  1  add: decimal carry-out; sub: 1 = no borrow (result >= 0), 0 = borrow (sum is ten's complement).
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when sum/c_out/invalid update.
invalid  output  1  registered with done; 1 if any captured digit of a or b was >9.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - Outputs: sum=0, c_out=0, busy=0, done=0, invalid=0.
  - Internal: state=IDLE, digit counter=0.
  - Applied mid-operation, reset aborts the operation; no done pulse follows.
- States: IDLE, RUN.
- IDLE with start=1 at edge E0:
  - Capture a.
  - Capture b, or its nine's complement (9-digit, per digit) when sub=1.
  - Set the working carry to c_in (add) or ~c_in (sub).
  - Capture sub.
  - Compute the invalid flag from the raw a/b digits.
  - Clear the digit counter; go to RUN; busy=1 from E0.
- start is ignored in RUN. Changes to a/b/sub/c_in after E0 have no effect.
- RUN, each edge: add the digit at the counter index using the per-digit rule below, shift the corrected digit into the working result register, update the working carry, and increment the counter.
- Per-digit rule:
  - t = a_d + b_d + carry (5 bits).
  - If t>9: digit = t+6 (low 4 bits), carry = 1.
  - Else: digit = t, carry = 0.
- Completion: at the edge where the counter reaches DIGITS-1 (edge E_DIGITS), the block:
  - loads sum with the full result and c_out with the final carry;
  - loads the invalid flag;
  - pulses done=1 for the following cycle;
  - sets busy=0 and returns to IDLE.
- Latency is exactly DIGITS cycles from start sampling to done. sum/c_out never show partial values.
- Invalid input: the computation still runs for full latency, but at completion sum=0, c_out=0, invalid=1. Otherwise invalid=0.
- Back-to-back operation: start is accepted in the cycle done is high (state is IDLE). This gives throughput of one result per DIGITS cycles. sum holds until the next completion.
- Simultaneous rst and start: rst wins.
- Wrap-around: 9...9 + 1 gives sum=0 with c_out=1. No saturation.

Decomposition:
- Package bcd_pkg holds:
  - BCD_W=4, BCD_MAX=9, BCD_CORR=6;
  - the state enum (IDLE, RUN);
  - a nines-complement function;
  - a digit-valid function.
- Sub-module bcd_digit_add is combinational: inputs a_d, b_d, cin; outputs d, cout; it implements the per-digit rule. It is instantiated once and reused each cycle.
- The top level holds the FSM, counter, shift registers and output registers.

Test Plan:
1. DIGITS=4, a=0025, b=0034, sub=0, c_in=0, start pulse -> busy high 4 cycles; done at cycle 4 with sum=0059, c_out=0, invalid=0.
2. a=9999, b=0001, add -> sum=0000, c_out=1. Then a=0888, b=0888, c_in=1 -> sum=1777, c_out=0.
3. Subtraction. a=0100, b=0001, sub=1, c_in=0 -> sum=0099, c_out=1. a=0001, b=0002, sub=1 -> sum=9999, c_out=0 (borrow).
4. Invalid input. a=000A, b=0001 -> done at cycle 4 with invalid=1, sum=0000, c_out=0. Next valid op clears invalid.
5. Handshake.
   - start re-asserted during busy is ignored (single done).
   - start in the done cycle starts a second op whose done comes 4 cycles later.
   - Operand changes after start do not affect the result.
6. Reset. rst asserted at cycle 2 of RUN -> no done, all outputs 0, busy=0. A new start after rst completes normally. Repeat test 1 with DIGITS=1 (a=5, b=7 -> sum=2, c_out=1, latency 1).
